// File: rtl/btn_cmd_arbiter.sv
// Push-button front end: per-button sync + debounce filter, press latching,
// and a round-robin arbiter that serialises presses into a valid/ready command stream.
module btn_cmd_arbiter #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned CODE_W        = 2
) (
  input  logic              CLK_FPGA,
  input  logic              RST_N,
  input  logic [N_BTN-1:0]  Btn,
  output logic              Cmd_valid,
  input  logic              Cmd_ready,
  output logic [CODE_W-1:0] Cmd_code,
  output logic [N_BTN-1:0]  Pending,
  output logic              Overrun
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CODE_W-1:0] LAST_RST = CODE_W'(N_BTN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  logic [N_BTN-1:0]  sync1_q, sync1_d;
  logic [N_BTN-1:0]  sync2_q, sync2_d;
  logic [N_BTN-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [N_BTN];
  logic [CNT_W-1:0]  cnt_d [N_BTN];
  logic [N_BTN-1:0]  pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] last_q, last_d;
  state_e            state_q, state_d;

  logic [N_BTN-1:0]  press;
  logic [N_BTN-1:0]  clr;
  logic              accept;
  logic              found;
  logic [CODE_W-1:0] cand;

  // Synchronizers and debounce filters; press fires on the 0->1 flip of stable.
  always_comb begin
    sync1_d  = Btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        press[i]    = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Request latching: a press landing on the accept edge of the same button survives.
  always_comb begin
    accept = valid_q & Cmd_ready;
    clr    = '0;
    if (accept) begin
      clr[code_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | press;
    overrun_d = overrun_q | (|(press & pending_q & ~clr));
  end

  // Round-robin arbiter: scan upward from last+1, hold the offer until accepted.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    last_d  = last_q;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        for (int unsigned j = 1; j <= N_BTN; j++) begin
          cand = CODE_W'((32'(last_q) + j) % N_BTN);
          if (!found && pending_q[cand]) begin
            found  = 1'b1;
            code_d = cand;
          end
        end
        if (found) begin
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (Cmd_ready) begin
          valid_d = 1'b0;
          last_d  = code_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_FPGA) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      pending_q <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      last_q    <= LAST_RST;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      last_q    <= last_d;
      state_q   <= state_d;
    end
  end

  assign Cmd_valid = valid_q;
  assign Cmd_code  = code_q;
  assign Pending   = pending_q;
  assign Overrun   = overrun_q;

endmodule

// File: doc/btn_cmd_arbiter.md
# btn_cmd_arbiter

Front-end controller for the board push-buttons: filters N raw button inputs and latches each debounced press as a pending request. A round-robin arbiter then serialises the pending requests into one command stream, using a valid/ready handshake toward the protocol engines (UART/SPI/I2C command decoder). Each physical press produces exactly one command. A press is never dropped silently: when it cannot be queued, it is flagged.

## Interface
- N_BTN, 4, number of button inputs (2..8).
- STABLE_CYCLES, 50000, consecutive cycles a synchronised input must disagree with the filtered state before the filtered state changes (2..2^CNT_W−1).
- CNT_W, 16, width of each per-button filter counter.
- CODE_W, 2, width of Cmd_code; must equal ceil(log2(N_BTN)).
- CLK_FPGA  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- Btn  in  N_BTN  raw button levels, active-high, asynchronous to CLK_FPGA.
- Cmd_valid  out  1  command offered downstream.
- Cmd_ready  in  1  downstream accepts the command when high together with Cmd_valid.
- Cmd_code  out  CODE_W  index of the button being reported.
- Pending  out  N_BTN  per-button request latched, not yet accepted.
- Overrun  out  1  sticky; a press arrived for a button whose request was still pending.

## Operation
- Each button has its own 2-flop synchronizer (sync1, sync2), a filtered state `stable`, and a counter `cnt` of width CNT_W.
- Filter rule, evaluated each edge:
  - sync2 == stable: cnt <= 0.
  - sync2 != stable and cnt == STABLE_CYCLES−1: stable <= sync2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- A glitch shorter than STABLE_CYCLES cycles leaves `stable` unchanged.
- Press event: the edge on which `stable` goes 0→1 sets Pending[i].
- A release (1→0) generates no event.
- If Pending[i] is already 1 when a press event for button i occurs, set Overrun. Overrun is cleared only by reset.
- Exception: if the same edge also accepts command i, Pending[i] stays 1 (the new press wins) and Overrun is not set.
- Arbiter FSM, 2 states:
  - IDLE: if Pending != 0, select the first set bit scanning upward from (last+1) mod N_BTN, wrapping around. Register it into Cmd_code, set Cmd_valid <= 1, go to OFFER. Otherwise stay in IDLE with Cmd_valid 0.
  - OFFER: Cmd_valid and Cmd_code are held constant until accepted. Cmd_ready alone never changes Cmd_code.
  - OFFER exit, on Cmd_valid && Cmd_ready: clear Pending[Cmd_code], last <= Cmd_code, Cmd_valid <= 0, go to IDLE.
- Presses arriving during OFFER only set Pending; they never change the offered code.
- Reset values (RST_N low at an edge):
  - sync1, sync2, stable, cnt, Pending: 0.
  - Cmd_valid 0, Cmd_code 0, Overrun 0.
  - FSM in IDLE; last = N_BTN−1, so the first scan starts at button 0.
- Reset asserted mid-offer drops the command and all pending requests. A button held through reset produces one press after reset, once filtered.

## Timing
- Latency: Btn high, first sampled at edge k and held, gives sync2 high after edge k+1 and stable/Pending high after edge k+1+STABLE_CYCLES.
- Cmd_valid goes high after edge k+2+STABLE_CYCLES, provided the FSM was in IDLE with no other pending request.
- Handshake: the transfer completes on the edge where Cmd_valid && Cmd_ready. Cmd_valid is low for at least one cycle between commands, so peak throughput is 1 command per 2 cycles.
- Cmd_ready may be high permanently; it is ignored while Cmd_valid is low.
- A Btn pulse lasting exactly STABLE_CYCLES cycles after synchronisation is accepted; STABLE_CYCLES−1 cycles is rejected.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Bench uses STABLE_CYCLES=4 and N_BTN=4.
- Single press: Btn[2] high from edge k, Cmd_ready=1 → Pending[2] after edge k+5. Cmd_valid=1 with Cmd_code=2 after edge k+6 for one cycle. Pending=0 after edge k+7, Overrun=0.
- Bounce rejection: Btn[0] toggling 1,0,1,0 every 3 cycles, then low → no Pending, Cmd_valid stays 0. Then hold Btn[0] 6 cycles → exactly one command, code 0. A 3-cycle pulse produces nothing.
- Round-robin: Cmd_ready=0, press buttons 3, 1, 0 so all are pending; then Cmd_ready=1 → codes issued 0, 1, 3, then 0 again when re-pressed after 3. Cmd_code stays stable while Cmd_ready=0.
- Overrun: Cmd_ready=0, press Btn[1], release, press again → Overrun=1 and only one command with code 1 is issued. Press during the accept edge → Pending stays set, Overrun unchanged.
- Reset mid-operation: RST_N low for one edge while in OFFER with Pending=4'b1010 → all outputs 0 next cycle. A held Btn[3] gives code 3 after STABLE_CYCLES+3 edges following reset release.
